triangle_scan_controller: RTL
=============================

Name: triangle_scan_controller

Overview:
- Sequences the combinational triangle rasterizer across a triangle's screen-space bounding box, one candidate pixel per clock.
- Accepts one triangle over a valid/ready handshake and latches its vertices.
- Drives the rasterizer's vertex and x,y inputs, then streams covered pixel coordinates to the downstream pixel writer with backpressure.
- Sits between the triangle setup/command stage and the framebuffer write path.

Parameters:
- SCREEN_WIDTH, 640, horizontal resolution; valid x is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 480, vertical resolution; valid y is 0..SCREEN_HEIGHT-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tri_valid  input  1  upstream triangle is presented.
- tri_ready  output  1  block can accept a triangle.
- tri_vertices  input  60  {v3y,v3x,v2y,v2x,v1y,v1x}, 10 bits each, unsigned.
- rast_vertices  output  60  latched vertices in the same packing; drives the rasterizer vertex inputs.
- rast_x  output  10  scan x; drives the rasterizer x input.
- rast_y  output  10  scan y; drives the rasterizer y input.
- rast_covered  input  1  rasterizer says (rast_x,rast_y) is inside; tie to r!=0.
- pix_valid  output  1  covered pixel presented.
- pix_ready  input  1  downstream accepts pixel.
- pix_x  output  10  covered pixel x.
- pix_y  output  10  covered pixel y.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last scan position.

Behaviour:
- Reset: state=IDLE, tri_ready=1, pix_valid=0, done=0, busy=0, rast_x=rast_y=0, rast_vertices=0. Reset is synchronous and overrides everything, including mid-scan; any in-flight triangle is abandoned and no further pixels are emitted.
- States: IDLE, BBOX, SCAN, DONE.
- IDLE:
  - tri_ready=1.
  - On tri_valid&&tri_ready, latch tri_vertices into rast_vertices and go to BBOX.
  - tri_ready is low in every other state.
- BBOX (1 cycle):
  - Register minx/maxx/miny/maxy = unsigned min/max of the three vertex coords.
  - Set rast_x=minx, rast_y=miny, then go to SCAN.
  - If the box is empty after clipping (see Optional Feature), go directly to DONE.
- SCAN:
  - pix_valid = rast_covered (combinational from the current position); pix_x=rast_x, pix_y=rast_y.
  - Advance when !rast_covered || pix_ready; otherwise hold rast_x/rast_y unchanged.
  - pix_x/pix_y must stay stable while pix_valid && !pix_ready.
  - Advance order is raster order:
    - if rast_x<maxx, then rast_x+1;
    - else rast_x=minx and rast_y+1;
    - when advancing from (maxx,maxy), go to DONE instead.
- DONE (1 cycle): done=1, pix_valid=0, then IDLE.
- Latency: a triangle accepted in cycle T is at scan position 0 in cycle T+2.
  - A box of N positions with no stalls has done high in cycle T+2+N.
  - tri_ready is high again in cycle T+3+N.
- Degenerate triangles (collinear or all-equal vertices) are still scanned over their box; with all-equal vertices the box is 1 position.
- Arithmetic:
  - All coordinates are 10-bit unsigned.
  - Comparisons are unsigned.
  - Counters never exceed maxx/maxy, so there is no wrap.
- rast_vertices holds its value until the next accept.

Optional Feature:
- Macro: TRI_SCAN_CLIP_EN.
- Defined:
  - maxx=min(maxx,SCREEN_WIDTH-1) and maxy=min(maxy,SCREEN_HEIGHT-1).
  - If minx>=SCREEN_WIDTH or miny>=SCREEN_HEIGHT, the box is empty: BBOX goes to DONE, zero pixels are emitted, and done still pulses.
- Undefined: no clipping; the box spans the raw 0..1023 vertex range, and off-screen pixels may be emitted.

Test Plan:
- Vertices (0,0),(4,0),(0,4), pix_ready=1, rasterizer or bench model on rast_* -> exactly 25 positions scanned in raster order; pix_valid asserted only on covered positions; done in cycle T+27; tri_ready high in T+28.
- Same triangle, pix_ready toggled 1,0,0,1... -> no covered pixel lost or duplicated; pix_x/pix_y stable during stalls; total covered count equals the pix_ready=1 run.
- TRI_SCAN_CLIP_EN defined, vertices (630,470),(700,470),(630,500) -> x scans 630..639, y scans 470..479 (100 positions).
- TRI_SCAN_CLIP_EN defined, all vertices with x>=640 -> zero pix_valid; done pulses in T+2.
- Reset asserted 5 cycles into the SCAN of a 25-position box -> next cycle state=IDLE, pix_valid=0, tri_ready=1, done stays 0; a new triangle then scans correctly.
- Two triangles offered back-to-back, tri_valid held high -> second is accepted only in the cycle after the first's done, and its scan starts 2 cycles after that accept.

Source files
------------

// File: rtl/triangle_scan_controller.sv
// rtl/triangle_scan_controller.sv - raster-order bounding-box scan sequencer for a combinational triangle rasterizer
//
// Accepts one triangle, walks its bounding box one candidate pixel per clock,
// and forwards covered pixels downstream with backpressure.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   tri_valid/ready     triangle handshake; tri_vertices = {v3y,v3x,v2y,v2x,v1y,v1x}
//   rast_vertices       latched vertices to the rasterizer
//   rast_x, rast_y      current scan position to the rasterizer
//   rast_covered        rasterizer inside-test result for (rast_x, rast_y)
//   pix_valid/ready     covered pixel handshake; pix_x, pix_y = pixel coordinate
//   busy                high whenever not idle
//   done                one-cycle pulse after the last scan position
//
// Build option: TRI_SCAN_CLIP_EN clips the box to the screen; an off-screen
// box is treated as empty.

module triangle_scan_controller #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [59:0] tri_vertices,
  output logic [59:0] rast_vertices,
  output logic [9:0]  rast_x,
  output logic [9:0]  rast_y,
  input  logic        rast_covered,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        busy,
  output logic        done
);

  // Coordinates are 10 bits wide, so the screen cannot exceed 1024 in either axis.
  if (SCREEN_WIDTH < 1 || SCREEN_WIDTH > 1024 ||
      SCREEN_HEIGHT < 1 || SCREEN_HEIGHT > 1024) begin : g_bad_screen
    $error("triangle_scan_controller: screen size must be 1..1024 per axis");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BBOX = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [59:0] r_vertices;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_minx;
  logic [9:0]  r_maxx;
  logic [9:0]  r_maxy;

  logic [9:0]  w_v1x, w_v1y, w_v2x, w_v2y, w_v3x, w_v3y;
  logic [9:0]  w_minx, w_miny, w_maxx_raw, w_maxy_raw;
  logic [9:0]  w_maxx, w_maxy;
  logic        w_box_empty;
  logic        w_at_maxx;
  logic        w_last;
  logic        w_adv;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign w_v1x = r_vertices[9:0];
  assign w_v1y = r_vertices[19:10];
  assign w_v2x = r_vertices[29:20];
  assign w_v2y = r_vertices[39:30];
  assign w_v3x = r_vertices[49:40];
  assign w_v3y = r_vertices[59:50];

  assign w_minx     = min3(w_v1x, w_v2x, w_v3x);
  assign w_miny     = min3(w_v1y, w_v2y, w_v3y);
  assign w_maxx_raw = max3(w_v1x, w_v2x, w_v3x);
  assign w_maxy_raw = max3(w_v1y, w_v2y, w_v3y);

`ifdef TRI_SCAN_CLIP_EN
  localparam logic [9:0] LP_XLAST = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] LP_YLAST = 10'(SCREEN_HEIGHT - 1);

  assign w_maxx      = (w_maxx_raw > LP_XLAST) ? LP_XLAST : w_maxx_raw;
  assign w_maxy      = (w_maxy_raw > LP_YLAST) ? LP_YLAST : w_maxy_raw;
  // A box starting beyond the screen edge has nothing left after clipping.
  assign w_box_empty = (w_minx > LP_XLAST) || (w_miny > LP_YLAST);
`else
  assign w_maxx      = w_maxx_raw;
  assign w_maxy      = w_maxy_raw;
  assign w_box_empty = 1'b0;
`endif

  assign w_at_maxx = (r_x == r_maxx);
  assign w_last    = w_at_maxx && (r_y == r_maxy);
  // An uncovered position never waits on the downstream writer.
  assign w_adv     = !rast_covered || pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    tri_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    pix_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        tri_ready = 1'b1;
        busy      = 1'b0;
        if (tri_valid) begin
          w_next = S_BBOX;
        end
      end
      S_BBOX: begin
        w_next = w_box_empty ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        pix_valid = rast_covered;
        if (w_adv && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vertices <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_minx     <= '0;
      r_maxx     <= '0;
      r_maxy     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tri_valid) begin
            r_vertices <= tri_vertices;
          end
        end
        S_BBOX: begin
          r_minx <= w_minx;
          r_maxx <= w_maxx;
          r_maxy <= w_maxy;
          r_x    <= w_minx;
          r_y    <= w_miny;
        end
        S_SCAN: begin
          // The final position is held so the position never steps past the box.
          if (w_adv && !w_last) begin
            if (!w_at_maxx) begin
              r_x <= r_x + 10'd1;
            end else begin
              r_x <= r_minx;
              r_y <= r_y + 10'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rast_vertices = r_vertices;
  assign rast_x        = r_x;
  assign rast_y        = r_y;
  assign pix_x         = r_x;
  assign pix_y         = r_y;

endmodule
